key_bit_entry: RTL and testbench



---
 rtl/key_bit_entry.sv | 164 ++++++++++++++++
 tb/tb_key_bit_entry.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/key_bit_entry.sv
// Push-button front end: synchronise, (optionally) debounce and edge-detect start/key1/key2,
// then frame exactly WIDTH MSB-first serial bits. Define KEY_DEBOUNCE_EN to include the debounce filter.
module key_bit_entry #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     key1,
    input  logic                     key2,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic [$clog2(WIDTH)-1:0] bit_index,
    output logic                     frame_active,
    output logic                     frame_done,
    output logic                     key_conflict
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 16 || DEB_CYCLES < 1) begin : g_bad_param
        $error("key_bit_entry: WIDTH must be 2..16 and DEB_CYCLES >= 1");
    end

    logic [2:0] raw;
    logic [2:0] press;
    logic       s_p, k1_p, k2_p;

    assign raw = {key2, key1, start};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic s1_reg, s2_reg, lvl, lvl_d_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_reg <= 1'b0;
                s2_reg <= 1'b0;
            end else begin
                s1_reg <= raw[gi];
                s2_reg <= s1_reg;
            end
        end

`ifdef KEY_DEBOUNCE_EN
        localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
        logic          deb_reg;
        logic [DW-1:0] dcnt_reg;

        // Accept a new level only once it has differed from the current one for DEB_CYCLES cycles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_reg  <= 1'b0;
                dcnt_reg <= '0;
            end else if (s2_reg == deb_reg) begin
                dcnt_reg <= '0;
            end else if (dcnt_reg == DW'(DEB_CYCLES - 1)) begin
                deb_reg  <= s2_reg;
                dcnt_reg <= '0;
            end else begin
                dcnt_reg <= dcnt_reg + 1'b1;
            end
        end
        assign lvl = deb_reg;
`else
        assign lvl = s2_reg;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) lvl_d_reg <= 1'b0;
            else        lvl_d_reg <= lvl;
        end
        assign press[gi] = lvl & ~lvl_d_reg;
    end

    assign s_p  = press[0];
    assign k1_p = press[1];
    assign k2_p = press[2];

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            bit_out_reg, bit_out_next;
    logic            bit_valid_reg, bit_valid_next;
    logic [IW-1:0]   bit_index_reg, bit_index_next;
    logic            frame_active_reg, frame_active_next;
    logic            frame_done_reg, frame_done_next;
    logic            key_conflict_reg, key_conflict_next;
    logic            key_ok;

    // Key pulses right after a strobe are dropped so strobes never run back to back.
    assign key_ok = !(bit_valid_reg || key_conflict_reg);

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        bit_out_next      = bit_out_reg;
        bit_index_next    = bit_index_reg;
        bit_valid_next    = 1'b0;
        frame_active_next = frame_active_reg;
        frame_done_next   = 1'b0;
        key_conflict_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_p) begin
                    state_next        = COLLECT;
                    cnt_next          = '0;
                    frame_active_next = 1'b1;
                end
            end
            COLLECT: begin
                if (s_p) begin
                    cnt_next = '0;
                end else if (key_ok && k1_p && k2_p) begin
                    key_conflict_next = 1'b1;
                end else if (key_ok && (k1_p ^ k2_p)) begin
                    bit_out_next   = k1_p;
                    bit_valid_next = 1'b1;
                    bit_index_next = IW'(WIDTH - 1 - int'(cnt_reg));
                    cnt_next       = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_next        = DONE;
                        frame_active_next = 1'b0;
                    end
                end
            end
            DONE: begin
                frame_done_next = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            bit_out_reg      <= 1'b0;
            bit_valid_reg    <= 1'b0;
            bit_index_reg    <= '0;
            frame_active_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            key_conflict_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            bit_out_reg      <= bit_out_next;
            bit_valid_reg    <= bit_valid_next;
            bit_index_reg    <= bit_index_next;
            frame_active_reg <= frame_active_next;
            frame_done_reg   <= frame_done_next;
            key_conflict_reg <= key_conflict_next;
        end
    end

    assign bit_out      = bit_out_reg;
    assign bit_valid    = bit_valid_reg;
    assign bit_index    = bit_index_reg;
    assign frame_active = frame_active_reg;
    assign frame_done   = frame_done_reg;
    assign key_conflict = key_conflict_reg;
endmodule

// File: tb/tb_key_bit_entry.sv
// Directed bench for key_bit_entry: table of button steps plus bounce and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_key_bit_entry;
    localparam int WIDTH = 4;
    localparam int DEB   = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int LAT = 2 + DEB + 1;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, key1 = 1'b0, key2 = 1'b0;
    logic       bit_out, bit_valid, frame_active, frame_done, key_conflict;
    logic [1:0] bit_index;

    key_bit_entry #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key1(key1), .key2(key2),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_index(bit_index),
        .frame_active(frame_active), .frame_done(frame_done), .key_conflict(key_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct { logic b; logic [1:0] idx; int t; } ev_t;
    ev_t  bits_q[$];
    int   done_q[$];
    int   conf_q[$];
    int   dbl_cnt = 0;
    logic [2:0] pv = '0;

    // Event recorder: strobes are sampled 2 ns after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bit_valid) bits_q.push_back('{bit_out, bit_index, cyc});
        if (frame_done) done_q.push_back(cyc);
        if (key_conflict) conf_q.push_back(cyc);
        if (|({bit_valid, frame_done, key_conflict} & pv)) dbl_cnt++;
        pv = {bit_valid, frame_done, key_conflict};
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bit_out, bit_valid, bit_index, frame_active, frame_done, key_conflict});
    endfunction

    // Press the buttons in m = {key2,key1,start} cleanly for 10 cycles, then release for 10.
    task automatic press(input logic [2:0] m, output int t0);
        @(posedge clk); #1;
        {key2, key1, start} = m;
        t0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        {key2, key1, start} = 3'b000;
        repeat (10) @(posedge clk);
    endtask

    task automatic clear_q();
        bits_q.delete(); done_q.delete(); conf_q.delete();
    endtask

    // Check one single-bit step: exactly one strobe of (b, idx) at the expected latency.
    task automatic chk_bit(input string tag, input int t0, input int b, input int idx);
        chk({tag, "_nbits"}, bits_q.size(), 1);
        if (bits_q.size() == 1) begin
            chk({tag, "_bit"}, int'(bits_q[0].b), b);
            chk({tag, "_idx"}, int'(bits_q[0].idx), idx);
            chk({tag, "_lat"}, bits_q[0].t - t0, LAT);
        end
    endtask

    typedef struct {
        logic [2:0] mask;   // {key2,key1,start}
        int         n;      // expected bit strobes
        int         b;
        int         idx;
        int         conf;   // expected key_conflict pulses
        int         done;   // expected frame_done pulses
        int         act;    // frame_active after the step
    } step_t;

    step_t steps[$];

    initial begin
        int    t0;
        string tag;

        // no frame open: key2 ignored; then a frame of 0,1,1,0
        steps.push_back('{3'b100, 0, 0, 0, 0, 0, 0});
        steps.push_back('{3'b001, 0, 0, 0, 0, 0, 1});
        steps.push_back('{3'b100, 1, 0, 3, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 2, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 1, 0, 0, 1});
        steps.push_back('{3'b100, 1, 0, 0, 0, 1, 0});
        // basic frame 1,0,1,1
        steps.push_back('{3'b001, 0, 0, 0, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 3, 0, 0, 1});
        steps.push_back('{3'b100, 1, 0, 2, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 1, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 0, 0, 1, 0});
        // restart with start+key1 together after two bits
        steps.push_back('{3'b001, 0, 0, 0, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 3, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 2, 0, 0, 1});
        steps.push_back('{3'b011, 0, 0, 0, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 3, 0, 0, 1});
        steps.push_back('{3'b100, 1, 0, 2, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 1, 0, 0, 1});
        steps.push_back('{3'b100, 1, 0, 0, 0, 1, 0});
        // key conflict leaves the index alone
        steps.push_back('{3'b001, 0, 0, 0, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 3, 0, 0, 1});
        steps.push_back('{3'b110, 0, 0, 0, 1, 0, 1});
        steps.push_back('{3'b100, 1, 0, 2, 0, 0, 1});
        steps.push_back('{3'b100, 1, 0, 1, 0, 0, 1});
        steps.push_back('{3'b010, 1, 1, 0, 0, 1, 0});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;

        for (int i = 0; i < steps.size(); i++) begin
            clear_q();
            press(steps[i].mask, t0);
            tag = $sformatf("step%0d", i);
            if (steps[i].n == 1) chk_bit(tag, t0, steps[i].b, steps[i].idx);
            else chk({tag, "_nbits"}, bits_q.size(), 0);
            chk({tag, "_conf"}, conf_q.size(), steps[i].conf);
            chk({tag, "_done"}, done_q.size(), steps[i].done);
            if (steps[i].done == 1 && done_q.size() == 1)
                chk({tag, "_done_t"}, done_q[0] - t0, LAT + 1);
            chk({tag, "_active"}, int'(frame_active), steps[i].act);
        end

        // bouncing key1 must yield a single bit, timed from the last clean edge
        press(3'b001, t0);
        clear_q();
        @(posedge clk); #1;
`ifdef KEY_DEBOUNCE_EN
        for (int i = 0; i < 10; i++) begin
            key1 = ((i / 2) % 2) == 0;
            if (i == 8) t0 = cyc;
            @(posedge clk); #1;
        end
        repeat (15) @(posedge clk);
        #1;
        key1 = 1'b0;
        repeat (12) @(posedge clk);
`else
        key1 = 1'b1;
        t0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        key1 = 1'b0;
        repeat (10) @(posedge clk);
`endif
        chk_bit("bounce", t0, 1, 3);

        // second bit, then reset mid-frame
        clear_q();
        press(3'b100, t0);
        chk_bit("pre_rst", t0, 0, 2);
        @(posedge clk); #1;
        chk("pre_rst_active", int'(frame_active), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        clear_q();
        press(3'b010, t0);
        chk("post_rst_nbits", bits_q.size(), 0);
        chk("post_rst_done", done_q.size(), 0);
        chk("post_rst_active", int'(frame_active), 0);
        press(3'b001, t0);
        clear_q();
        press(3'b010, t0);
        chk_bit("post_rst_first", t0, 1, 3);

        chk("no_double_pulse", dbl_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
